// File: rtl/piso_bit_serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and default word width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Word-in / bit-out bundle between an upstream word source and the serializer.
// Latency: n/a (wiring only).
// Backpressure: din_ready from the serializer gates din_valid transfers.
//
// slave  : serializer side (takes din/din_valid, drives ready and serial outputs)
// master : source/observer side
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport slave (
    input  din, din_valid,
    output din_ready, x_out, x_valid, busy, done
  );

  modport master (
    output din, din_valid,
    input  din_ready, x_out, x_valid, busy, done
  );

endinterface

// File: rtl/piso_bit_serializer_counter.sv
// Bit-position up-counter with synchronous clear/enable and terminal-count flags.
// Latency: count updates one edge after clr/en; tc is the current count, tc_nxt the next.
// Backpressure: none; the owner decides when to clear or advance.
//
// Ports: clk, rst (async active-low), clr (wins over en), en,
//        tc (count == MAX), tc_nxt (count after this edge will equal MAX).
module ser_bit_counter #(
  parameter int MAX   = 7,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic tc_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc     = (cnt_q == CNT_W'(MAX));
  assign tc_nxt = (cnt_d == CNT_W'(MAX));

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out: WIDTH-bit words leave MSB first, one bit per clock.
// Latency: MSB on x_out the cycle after the accept edge; a word fills WIDTH (WIDTH+1 with parity) cycles.
// Backpressure: din_ready high in IDLE and on the final output cycle of a word, so words stream gap-free.
//
// Ports: clk, rst (async active-low), bus (slave modport: din/din_valid/din_ready,
//        x_out/x_valid serial line, busy, done pulse on the final cycle of a word).
// Optional: define SERIALIZER_PARITY_EN to append one even-parity bit per word.
module piso_bit_serializer
  import serial_pkg::*;
#(
  parameter  int WIDTH = SER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_bit_serializer_if.slave  bus
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en, cnt_tc, cnt_tc_nxt;
  logic             din_ready_c;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  ser_bit_counter #(
    .MAX   (WIDTH - 1),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (cnt_tc),
    .tc_nxt (cnt_tc_nxt)
  );

  // Ready is decoded from state only, keeping it free of any din_valid loop.
  always_comb begin
    din_ready_c = 1'b0;
    case (state_q)
      S_IDLE:  din_ready_c = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      // With parity the last data bit is followed by PAR, so the reload slot moves there.
      S_PAR:   din_ready_c = 1'b1;
`else
      S_SHIFT: din_ready_c = cnt_tc;
`endif
      default: din_ready_c = 1'b0;
    endcase
  end

  assign accept = bus.din_valid & din_ready_c;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d   = accept ? ^bus.din : par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sreg_d  = bus.din;
          cnt_clr = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_q << 1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = S_PAR;
`else
          cnt_clr = 1'b1;
          if (accept) begin
            sreg_d = bus.din;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PAR: begin
        cnt_clr = 1'b1;
        if (accept) begin
          sreg_d  = bus.din;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Outputs are precomputed from next-state so x_out/x_valid/done are all flops.
  always_comb begin
    x_valid_d = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
    x_out_d   = 1'b0;
    if (state_d == S_SHIFT) begin
      x_out_d = sreg_d[WIDTH-1];
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_d == S_PAR) begin
      x_out_d = par_d;
    end
    done_d = (state_d == S_PAR);
`else
    done_d = (state_d == S_SHIFT) && cnt_tc_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sreg_q    <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign bus.din_ready = din_ready_c;
  assign bus.x_out     = x_out_q;
  assign bus.x_valid   = x_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the serial sequence detectors (for example the "101" Mealy detector). It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single serial line with a qualifying valid strobe. Back-to-back words stream with no idle gap, so the downstream detector sees a contiguous bit stream across word boundaries.

Parameters:
WIDTH, 8, data word width in bits (≥2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word to transfer
din_ready  output  1  serializer can accept din this cycle
x_out  output  1  serial bit to downstream detector input x
x_valid  output  1  x_out carries a real data bit this cycle
busy  output  1  word in flight (state ≠ IDLE)
done  output  1  one-cycle pulse coincident with last bit of a word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, counter=0, x_out=0, x_valid=0, busy=0, done=0. din_ready is combinational and reads 1 in IDLE. Reset asserted mid-word aborts it immediately; the remaining bits are discarded and never emitted.
- Accept: a transfer occurs on a rising edge with din_valid=1 and din_ready=1. din is captured into the shift register on that edge.
- din_ready = (state==IDLE) OR (state==SHIFT AND counter==WIDTH-1, i.e. last bit is on x_out) OR (PAR state, when the parity feature is compiled in). It is 0 otherwise. din_valid while din_ready=0 is ignored and no data is captured. The upstream source must hold din stable until accepted.
- Latency: the MSB of an accepted word appears on x_out, with x_valid=1, in the cycle after the accept edge. Bit i (MSB=0) appears i+1 cycles after accept. A word occupies exactly WIDTH consecutive output cycles.
- FSM states:
  - IDLE: x_valid=0, x_out=0. On accept, go to SHIFT with counter=0.
  - SHIFT: x_out=sreg[WIDTH-1], x_valid=1. Each edge shifts left by one and increments counter.
  - At counter==WIDTH-1, done=1. On the next edge:
    - accept pending → reload, counter=0, stay in SHIFT, with no gap cycle.
    - otherwise → IDLE.
- Outputs x_out, x_valid, busy, done are registered, so there are no combinational paths from din to x_out.
- Idle line: x_out=0 while x_valid=0. The detector therefore sees zeros between words, which is intentional.
- Counter never exceeds WIDTH-1 (or WIDTH with parity), so there is no wrap-around.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, add state PAR, which emits one even-parity bit (XOR of the captured word).
  - In PAR: x_valid=1 and done=1, and done is not asserted on the last data bit.
  - Each word occupies WIDTH+1 cycles. din_ready is high in PAR to allow back-to-back transfer.
- Undefined: the PAR state, parity register and logic are absent, and behaviour is exactly as described above.

Decomposition:
- Shared package serial_pkg:
  - state enum typedef ser_state_t {S_IDLE, S_SHIFT, S_PAR}
  - default word width constant SER_WIDTH=8
- One natural sub-module: ser_bit_counter (up-counter with clear/enable and terminal-count flag), instantiated once.
- Handshake, shift register and FSM remain in the top module.

Test Plan:
1. Reset, then din=8'hA5 accepted once. x_out = 1,0,1,0,0,1,0,1 on cycles 1–8 after accept, x_valid high for exactly those 8 cycles, done high on cycle 8 only, then IDLE with din_ready=1.
2. Back-to-back 8'hA5 then 8'h5A, din_valid held. Second accept happens on the last-bit cycle, giving 16 contiguous valid bits 10100101 01011010 with no gap. Fed to the s101 detector, this yields y pulses at every overlapping "101".
3. din=8'hFF accepted, then din=8'h00 presented with din_valid=1 at cycles 2–6. din_ready=0 there, so the second word is not captured until the last-bit cycle, and the output stays 11111111.
4. Accept 8'hC3. After 3 bits (1,1,0), pull rst low for one cycle. All outputs go 0 immediately; after release state=IDLE, din_ready=1, and the remaining bits are never emitted.
5. With SERIALIZER_PARITY_EN defined:
   - 8'hA5 → 9 bits ending in parity 0.
   - 8'h07 → 9 bits ending in parity 1.
   - done is high only on the parity cycle.
6. WIDTH=4, din=4'b1001 → x_out 1,0,0,1 over 4 cycles, with done on the 4th.
